// File: rtl/arb3_rr.sv
// Three-requester round-robin arbiter with hold/release handshake.
// Define ARB_TIMEOUT_EN to add the HOLD_MAX grant timeout, MASK and FLUSH cycle.
module arb3_rr #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic       CLK,
  input  logic       R,
  input  logic [2:0] REQ,
  input  logic       DONE,
  output logic [2:0] GNT,
  output logic [1:0] GID,
  output logic       BUSY,
  output logic       TOUT
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
`ifdef ARB_TIMEOUT_EN
  localparam logic [1:0] S_FLUSH = 2'd2;
`endif

  logic [1:0] state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] gnt_q, gnt_d;
  logic [1:0] gid_q, gid_d;
  logic       busy_q, busy_d;
  logic [2:0] elig;
  logic       pickOk;
  logic [1:0] pickIdx;
  logic [1:0] ord0, ord1, ord2;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] mask_q, mask_d;
  logic [2:0] maskSet;
  logic       tout_q, tout_d;

  assign elig = REQ & ~mask_q;
  assign TOUT = tout_q;
`else
  assign elig = REQ;
  assign TOUT = 1'b0;
`endif

  // Search order starts just after the last granted index; a masked requester is skipped
  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    unique case (ptr_q)
      2'd0: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd1: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
    pickOk  = 1'b0;
    pickIdx = 2'd0;
    if (elig[ord2]) begin pickOk = 1'b1; pickIdx = ord2; end
    if (elig[ord1]) begin pickOk = 1'b1; pickIdx = ord1; end
    if (elig[ord0]) begin pickOk = 1'b1; pickIdx = ord0; end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    gid_d   = gid_q;
    busy_d  = busy_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    maskSet = 3'b000;
    tout_d  = tout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pickOk) begin
          state_d = S_GRANT;
          gnt_d   = 3'b001 << pickIdx;
          gid_d   = pickIdx;
          busy_d  = 1'b1;
          ptr_d   = pickIdx;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      S_GRANT: begin
        // Release by the owner wins over a timeout landing on the same edge
        if (DONE || !REQ[gid_q]) begin
          state_d = S_IDLE;
          gnt_d   = 3'b000;
          gid_d   = 2'b11;
          busy_d  = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == 8'(HOLD_MAX - 1)) begin
          state_d = S_FLUSH;
          gnt_d   = 3'b000;
          gid_d   = 2'b11;
          busy_d  = 1'b0;
          tout_d  = 1'b1;
          maskSet = 3'b001 << gid_q;
        end
        else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
`ifdef ARB_TIMEOUT_EN
      S_FLUSH: begin
        state_d = S_IDLE;
        tout_d  = 1'b0;
      end
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    mask_d = (mask_q | maskSet) & REQ;
`endif
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd2;
      gnt_q   <= 3'b000;
      gid_q   <= 2'b11;
      busy_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
      mask_q  <= 3'b000;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      tout_q  <= tout_d;
`endif
    end
  end

  assign GNT  = gnt_q;
  assign GID  = gid_q;
  assign BUSY = busy_q;

endmodule

// File: tb/tb_arb3_rr.sv
// Scoreboard bench for arb3_rr: driver queues expected outputs, monitor checks them after each edge.
module tb_arb3_rr;

  logic       CLK;
  logic       R;
  logic [2:0] REQ;
  logic       DONE;
  logic [2:0] GNT;
  logic [1:0] GID;
  logic       BUSY;
  logic       TOUT;

  typedef struct packed {
    logic [2:0] gnt;
    logic [1:0] gid;
    logic       busy;
    logic       tout;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   errorCount = 0;
  int   stepNum    = 0;

  arb3_rr #(.HOLD_MAX(4)) dut (
    .CLK (CLK),
    .R   (R),
    .REQ (REQ),
    .DONE(DONE),
    .GNT (GNT),
    .GID (GID),
    .BUSY(BUSY),
    .TOUT(TOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t makeExp(input logic [2:0] g, input logic t);
    exp_t e;
    e.gnt  = g;
    e.busy = (g != 3'b000);
    e.tout = t;
    case (g)
      3'b001:  e.gid = 2'd0;
      3'b010:  e.gid = 2'd1;
      3'b100:  e.gid = 2'd2;
      default: e.gid = 2'b11;
    endcase
    return e;
  endfunction

  task automatic checkOutput(input string name, input exp_t e);
    exp_t act;
    act = '{gnt: GNT, gid: GID, busy: BUSY, tout: TOUT};
    checkCount++;
    if (act !== e) begin
      errorCount++;
      $display("[TB] FAIL %s: got GNT=%b GID=%b BUSY=%b TOUT=%b, want GNT=%b GID=%b BUSY=%b TOUT=%b",
               name, act.gnt, act.gid, act.busy, act.tout, e.gnt, e.gid, e.busy, e.tout);
    end
  endtask

  // Inputs change just after the falling edge; the expectation applies after the next rising edge
  task automatic applyStimulus(input logic [2:0] req, input logic done,
                               input logic [2:0] expGnt, input logic expTout);
    @(negedge CLK);
    #1;
    REQ  = req;
    DONE = done;
    expQ.push_back(makeExp(expGnt, expTout));
  endtask

  always @(posedge CLK) begin
    #2;
    if (expQ.size() > 0) begin
      stepNum++;
      checkOutput($sformatf("step%0d", stepNum), expQ.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    R = 1'b0;
    REQ = 3'b000;
    DONE = 1'b0;
    #12;
    checkOutput("reset_state", makeExp(3'b000, 1'b0));
    @(negedge CLK);
    R = 1'b1;

    // single request then release
    applyStimulus(3'b001, 1'b0, 3'b001, 1'b0);
    applyStimulus(3'b001, 1'b1, 3'b000, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);

    // round robin from PTR=0: 1,2,0,1,2,0 with a dead cycle between owners
    for (int i = 0; i < 2; i++) begin
      applyStimulus(3'b111, 1'b0, 3'b010, 1'b0);
      applyStimulus(3'b111, 1'b1, 3'b000, 1'b0);
      applyStimulus(3'b111, 1'b0, 3'b100, 1'b0);
      applyStimulus(3'b111, 1'b1, 3'b000, 1'b0);
      applyStimulus(3'b111, 1'b0, 3'b001, 1'b0);
      applyStimulus(3'b111, 1'b1, 3'b000, 1'b0);
    end
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);

    // pointer skip: last owner 0, REQ=101 gives 2 then 0
    applyStimulus(3'b101, 1'b0, 3'b100, 1'b0);
    applyStimulus(3'b101, 1'b1, 3'b000, 1'b0);
    applyStimulus(3'b101, 1'b0, 3'b001, 1'b0);
    applyStimulus(3'b101, 1'b1, 3'b000, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);

    // release by request drop, then DONE in idle is ignored
    applyStimulus(3'b010, 1'b0, 3'b010, 1'b0);
    applyStimulus(3'b010, 1'b0, 3'b010, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    applyStimulus(3'b000, 1'b1, 3'b000, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // forced release after 4 cycles, FLUSH, masked until REQ[1] drops
    for (int i = 0; i < 4; i++) applyStimulus(3'b010, 1'b0, 3'b010, 1'b0);
    applyStimulus(3'b010, 1'b0, 3'b000, 1'b1);
    applyStimulus(3'b010, 1'b0, 3'b000, 1'b0);
    applyStimulus(3'b010, 1'b0, 3'b000, 1'b0);
    applyStimulus(3'b010, 1'b0, 3'b000, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);
    applyStimulus(3'b010, 1'b0, 3'b010, 1'b0);
    applyStimulus(3'b010, 1'b1, 3'b000, 1'b0);

    // DONE on the 4th grant cycle beats the timeout; requester stays unmasked
    for (int i = 0; i < 4; i++) applyStimulus(3'b001, 1'b0, 3'b001, 1'b0);
    applyStimulus(3'b001, 1'b1, 3'b000, 1'b0);
    applyStimulus(3'b001, 1'b0, 3'b001, 1'b0);
    applyStimulus(3'b001, 1'b1, 3'b000, 1'b0);
`else
    // without timeout a grant is held indefinitely
    for (int i = 0; i < 8; i++) applyStimulus(3'b100, 1'b0, 3'b100, 1'b0);
    applyStimulus(3'b100, 1'b1, 3'b000, 1'b0);
`endif

    // async reset mid-grant
    applyStimulus(3'b100, 1'b0, 3'b100, 1'b0);
    applyStimulus(3'b100, 1'b0, 3'b100, 1'b0);
    @(posedge CLK);
    #4;
    R = 1'b0;
    REQ = 3'b000;
    #1;
    checkOutput("async_reset", makeExp(3'b000, 1'b0));
    @(negedge CLK);
    R = 1'b1;
    applyStimulus(3'b111, 1'b0, 3'b001, 1'b0);
    applyStimulus(3'b111, 1'b1, 3'b000, 1'b0);
    applyStimulus(3'b000, 1'b0, 3'b000, 1'b0);

    repeat (3) @(posedge CLK);
    #4;
    checkCount++;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/arb3_rr.md
# arb3_rr

Three-requester round-robin arbiter with hold/release handshake and optional grant timeout. It shares one resource (a bus slice or a shared scan/test port built from the standard-cell library) among requesters 0..2. The resource owner is chosen fairly, and the grant is held until the owner releases it. It sits between the requesting blocks and the resource's select logic, and drives the one-hot select directly.

## Interface

Parameters:
- HOLD_MAX, 16: maximum cycles a grant may be held before forced release. Legal range 2..255; 8-bit counter. Used only with ARB_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- R  in  1  asynchronous active-low reset.
- REQ  in  3  request level per requester; held high until served.
- DONE  in  1  release strobe from the current owner; sampled only while a grant is active.
- GNT  out  3  one-hot grant, registered; all zeros when idle.
- GID  out  2  index of the granted requester; 2'b11 when none.
- BUSY  out  1  equals |GNT, registered.
- TOUT  out  1  one-cycle pulse on forced release.

## Operation

- Reset (R=0, asynchronous) sets:
  - GNT=000, GID=11, BUSY=0, TOUT=0.
  - State IDLE.
  - Pointer PTR=2, so requester 0 has first priority.
  - Hold counter CNT=0 and MASK=000.
- Eligible set: E = REQ & ~MASK.
- **IDLE**
  - If E≠0 at an edge, grant the first eligible index after PTR in order PTR+1, PTR+2, PTR (mod 3).
  - Load GNT, GID and BUSY. Set PTR to the granted index, clear CNT, go to GRANT.
  - If E=0, stay in IDLE.
- **GRANT**, with g = GID. Checked in priority order at each edge:
  - (a) DONE=1 or REQ[g]=0: release. Go to IDLE with GNT=000, GID=11, BUSY=0.
  - (b) Timeout: CNT==HOLD_MAX-1, timeout compiled in. Go to FLUSH with GNT=000, GID=11, BUSY=0. Set TOUT=1 and MASK[g]=1.
  - (c) Otherwise: CNT+=1, hold GNT.
- **FLUSH**
  - Lasts one cycle; TOUT=1 during it. No arbitration.
  - Next edge: TOUT=0, go to IDLE.
- MASK[i] is cleared at any edge where REQ[i]=0. Clearing has priority over setting only when both occur at the same edge.
- DONE while in IDLE or FLUSH is ignored.
- A requester that drops REQ while not granted simply leaves the eligible set. No other state changes.
- PTR changes only on grant issue. A masked requester is skipped without moving PTR.

## Timing

- Grant latency: REQ high at edge k in IDLE gives GNT high after edge k (registered).
  - Minimum REQ-to-GNT is one edge.
- Release latency:
  - DONE sampled at edge n gives GNT=000 after edge n.
  - A new grant is issued at edge n+1 at the earliest.
  - There is always at least one dead cycle between owners.
- Forced release: GNT stays high for exactly HOLD_MAX cycles. It is followed by the FLUSH cycle (TOUT=1), then IDLE; the next grant is no earlier than 2 cycles after the drop.
- DONE and timeout at the same edge: DONE wins. TOUT stays 0 and MASK is unchanged.
- R asserted mid-grant: GNT drops immediately, without waiting for CLK.
- Outputs are glitch-free: all are flop outputs, with no combinational paths from inputs.

## Configuration

- ARB_TIMEOUT_EN defined:
  - CNT, MASK, FLUSH state and TOUT logic are present.
  - HOLD_MAX is honoured.
- ARB_TIMEOUT_EN undefined:
  - No counter, no MASK and no FLUSH state. TOUT is tied to 0 and E=REQ.
  - A grant is held indefinitely until DONE or REQ[g]=0.
  - HOLD_MAX is ignored.

## Test plan

- **Reset then single request:** R low→high, REQ=001 → GNT=001, GID=00, BUSY=1 one edge later. DONE pulse → GNT=000 next edge.
- **Round-robin fairness:** REQ=111 held, DONE pulsed each time a grant is seen → grant order 0,1,2,0,1,2. Exactly one dead cycle between grants.
- **Pointer skip:** grant 0 then release, REQ=101 → next grant 2, then 0.
- **Timeout (HOLD_MAX=4, macro on):** REQ=010 held, no DONE. Response:
  - GNT=010 for exactly 4 cycles.
  - TOUT pulse for 1 cycle.
  - Requester 1 is not regranted while REQ[1] stays high.
  - After REQ[1] drops and rises again, it is regranted.
- **DONE/timeout collision (HOLD_MAX=4):** DONE asserted on the 4th grant cycle → clean release, TOUT stays 0, MASK=000.
- **Async reset mid-grant:** GNT=100, R pulsed low between clock edges → GNT=000, GID=11 immediately. First grant after reset goes to requester 0 when REQ=111.
